// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams program words into the MIPS unified memory port and
// holds the core in reset until the image is in place.
// Optional readback verification is compiled in when LOADER_VERIFY_EN is defined.
module mem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 32
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        start,
  input  logic        src_valid,
  input  logic [31:0] src_data,
  output logic        src_ready,
  output logic [31:0] MemoryAddress,
  output logic [31:0] MemoryWD,
  output logic        MemoryWE,
  input  logic [31:0] MemoryRD,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    StIdle, StWrAcc, StWrPulse, StRdReq, StRdCap, StCheck, StDone, StError
  } state_e;
`else
  typedef enum logic [2:0] {StIdle, StWrAcc, StWrPulse, StDone} state_e;
`endif

  state_e          r_state;
  state_e          w_state_next;
  logic [IdxW-1:0] r_idx;
  logic [IdxW-1:0] w_idx_inc;
  logic            w_last;
  logic [31:0]     w_addr_cur;
  logic [31:0]     r_addr;
  logic [31:0]     r_wd;
  logic [31:0]     r_checksum;
  logic            r_we;
  logic            r_done;
  logic            r_cpu_reset;
  logic            w_src_ready;
  logic            w_we_next;
  logic            w_done_next;
  logic            w_idle_like;
  logic            w_restart;

`ifdef LOADER_VERIFY_EN
  logic [31:0] r_rdsum;
  logic [31:0] w_addr_inc;
  logic        r_error;
  logic        w_error_next;

  assign w_idle_like = (r_state == StIdle) || (r_state == StDone) || (r_state == StError);
  assign w_addr_inc  = BASE_ADDR + (32'(w_idx_inc) << 2);
`else
  logic w_unused_rd;

  // Readback is compiled out, so the read port is intentionally left unused.
  assign w_unused_rd = ^MemoryRD;
  assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
`endif

  assign w_restart  = start && w_idle_like;
  assign w_last     = (r_idx == LastIdx);
  assign w_idx_inc  = r_idx + IdxW'(1);
  assign w_addr_cur = BASE_ADDR + (32'(r_idx) << 2);

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (start) w_state_next = StWrAcc;
      StWrAcc:   if (src_valid) w_state_next = StWrPulse;
`ifdef LOADER_VERIFY_EN
      StWrPulse: w_state_next = w_last ? StRdReq : StWrAcc;
      StRdReq:   w_state_next = StRdCap;
      StRdCap:   w_state_next = w_last ? StCheck : StRdReq;
      StCheck:   w_state_next = (r_rdsum == r_checksum) ? StDone : StError;
      StError:   if (start) w_state_next = StWrAcc;
`else
      StWrPulse: w_state_next = w_last ? StDone : StWrAcc;
`endif
      StDone:    if (start) w_state_next = StWrAcc;
      default:   w_state_next = StIdle;
    endcase
  end

  // Output decode; everything except src_ready is registered below.
  // A restart clears done/error on the same edge that leaves DONE/ERROR.
  always_comb begin
    w_src_ready  = (r_state == StWrAcc);
    w_we_next    = (w_state_next == StWrPulse);
    w_done_next  = (r_state == StDone) && !start;
`ifdef LOADER_VERIFY_EN
    w_error_next = (r_state == StError) && !start;
`endif
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_we        <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_reset <= 1'b1;
`ifdef LOADER_VERIFY_EN
      r_error     <= 1'b0;
`endif
    end else begin
      r_we        <= w_we_next;
      r_done      <= w_done_next;
      r_cpu_reset <= !w_done_next;
`ifdef LOADER_VERIFY_EN
      r_error     <= w_error_next;
`endif
    end
  end

  // Datapath: index, address/data latches and running sums.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_idx      <= '0;
      r_addr     <= BASE_ADDR;
      r_wd       <= 32'h0;
      r_checksum <= 32'h0;
`ifdef LOADER_VERIFY_EN
      r_rdsum    <= 32'h0;
`endif
    end else if (w_restart) begin
      r_idx      <= '0;
      r_checksum <= 32'h0;
`ifdef LOADER_VERIFY_EN
      r_rdsum    <= 32'h0;
`endif
    end else begin
      case (r_state)
        StWrAcc: begin
          if (src_valid) begin
            r_wd       <= src_data;
            r_addr     <= w_addr_cur;
            r_checksum <= r_checksum + src_data;
          end
        end
        StWrPulse: begin
          if (!w_last) begin
            r_idx <= w_idx_inc;
`ifdef LOADER_VERIFY_EN
          end else begin
            // Present word 0's address during the first RD_REQ cycle.
            r_idx  <= '0;
            r_addr <= BASE_ADDR;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        StRdCap: begin
          r_rdsum <= r_rdsum + MemoryRD;
          if (!w_last) begin
            r_idx  <= w_idx_inc;
            r_addr <= w_addr_inc;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign src_ready     = w_src_ready;
  assign MemoryAddress = r_addr;
  assign MemoryWD      = r_wd;
  assign MemoryWE      = r_we;
  assign cpu_reset     = r_cpu_reset;
  assign done          = r_done;
  assign checksum      = r_checksum;
`ifdef LOADER_VERIFY_EN
  assign error         = r_error;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader with a write scoreboard and a simple
// synchronous memory model; adapts done latency to LOADER_VERIFY_EN.
module tb_mem_boot_loader;

  localparam int unsigned NumWords = 4;
  localparam logic [31:0] Base     = 32'h0000_0000;
`ifdef LOADER_VERIFY_EN
  localparam int unsigned DoneLat  = 4 * NumWords + 2;
`else
  localparam int unsigned DoneLat  = 2 * NumWords + 1;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        RESET;
  logic        start;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic [31:0] MemoryAddress;
  logic [31:0] MemoryWD;
  logic        MemoryWE;
  logic [31:0] MemoryRD;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        corrupt = 1'b0;
  logic [31:0] mem [0:31];
  logic [31:0] prog [0:3] = '{32'h8C01_0020, 32'hAC01_0024, 32'h8C02_0028, 32'h2043_0001};
  wr_t         exp_q [$];
  wr_t         mon_e;

  mem_boot_loader #(
    .BASE_ADDR(Base),
    .NUM_WORDS(NumWords)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .start        (start),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .MemoryAddress(MemoryAddress),
    .MemoryWD     (MemoryWD),
    .MemoryWE     (MemoryWE),
    .MemoryRD     (MemoryRD),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: read data reflects the address sampled at the last edge.
  initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (MemoryWE)
      mem[MemoryAddress[6:2]] <= (corrupt && MemoryAddress == 32'h8) ? 32'h8C02_0029 : MemoryWD;
    MemoryRD <= mem[MemoryAddress[6:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write pulse must match the next expected word.
  always @(negedge clk) begin
    if (MemoryWE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("we_addr", MemoryAddress, mon_e.a);
        chk("we_data", MemoryWD, mon_e.d);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!src_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!src_ready) chk("ready_timeout", 32'(src_ready), 32'd1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic load(input int stall_idx, input int drop_start_idx);
    for (int i = 0; i < int'(NumWords); i++) begin
      if (i == stall_idx) begin
        src_valid = 1'b0;
        wait_ready();
        for (int k = 0; k < 3; k++) begin
          chk("stall_ready", 32'(src_ready), 32'd1);
          chk("stall_no_we", 32'(MemoryWE), 32'd0);
          @(negedge clk);
        end
      end
      src_valid = 1'b1;
      src_data  = prog[i];
      exp_q.push_back('{a: Base + 32'(i) * 32'd4, d: prog[i]});
      wait_ready();
      @(posedge clk);
      #1;
      if (i == drop_start_idx) start = 1'b0;
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned lat);
    int n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(cyc - start_cyc), lat);
  endtask

  initial begin
    RESET     = 1'b1;
    start     = 1'b0;
    src_valid = 1'b0;
    src_data  = 32'h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_src_ready", 32'(src_ready), 32'd0);
    chk("rst_we", 32'(MemoryWE), 32'd0);
    chk("rst_addr", MemoryAddress, Base);
    chk("rst_wd", MemoryWD, 32'h0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_checksum", checksum, 32'h0);
    RESET = 1'b0;

    // Reset held two cycles in the middle of a WR_PULSE.
    do_start();
    src_valid = 1'b1;
    src_data  = prog[0];
    exp_q.push_back('{a: Base, d: prog[0]});
    @(posedge clk);
    #1;
    chk("midrst_pulse", 32'(MemoryWE), 32'd1);
    RESET     = 1'b1;
    src_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_we", 32'(MemoryWE), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_checksum", checksum, 32'h0);
    chk("midrst_src_ready", 32'(src_ready), 32'd0);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    RESET = 1'b0;

    // Nominal load.
    do_start();
    load(-1, -1);
    chk("nom_cpu_reset_busy", 32'(cpu_reset), 32'd1);
    wait_done("nom_latency", DoneLat);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_checksum", checksum, 32'hE447_006D);

    // Restart from DONE with start left high through the first writes.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    @(negedge clk);
    chk("restart_done_drop", 32'(done), 32'd0);
    chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
    load(-1, 1);
    wait_done("restart_latency", DoneLat);
    chk("restart_checksum", checksum, 32'hE447_006D);

    // Backpressure before word 2.
    do_start();
    load(2, -1);
    wait_done("stall_latency", DoneLat + 3);
    chk("stall_checksum", checksum, 32'hE447_006D);
    chk("stall_done", 32'(done), 32'd1);

`ifdef LOADER_VERIFY_EN
    // Corrupted readback of address 0x08.
    corrupt = 1'b1;
    do_start();
    load(-1, -1);
    wait_done("vfail_latency", DoneLat);
    chk("vfail_error", 32'(error), 32'd1);
    chk("vfail_done", 32'(done), 32'd0);
    chk("vfail_cpu_reset", 32'(cpu_reset), 32'd1);
    repeat (5) @(negedge clk);
    chk("vfail_sticky", 32'(error), 32'd1);
    corrupt = 1'b0;

    // Restart from ERROR with a clean memory.
    do_start();
    @(negedge clk);
    chk("err_restart_clear", 32'(error), 32'd0);
    load(-1, -1);
    wait_done("err_restart_latency", DoneLat);
    chk("err_restart_done", 32'(done), 32'd1);
    chk("err_restart_error", 32'(error), 32'd0);
`else
    repeat (5) @(negedge clk);
    chk("noverify_error", 32'(error), 32'd0);
    chk("noverify_done_sticky", 32'(done), 32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
